tdes_sched: RTL and testbench

TDES_SCHED -- requirements
Module: tdes_sched

---
 rtl/tdes_sched_pkg.sv | 18 +
 rtl/tdes_sched_if.sv | 26 ++
 rtl/tdes_rr_arb.sv | 19 +
 rtl/tdes_sched.sv | 126 ++++++++++++
 tb/tb_tdes_sched.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdes_sched_pkg.sv
// Shared types and defaults for the 3-DES decrypt scheduler.
// Blocks use DES bit numbering, bit 1 is the MSB.
package tdes_sched_pkg;

  typedef logic [1:64] block_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_FLUSH
  } state_t;

  localparam int TIMEOUT_DEF = 255;
  localparam int FLUSH_DEF   = 2;

endpackage

// File: rtl/tdes_sched_if.sv
// Requester channel: request handshake plus held response.
// master = requester side, slave = scheduler side.
interface tdes_sched_if;
  import tdes_sched_pkg::*;

  logic   req_valid;
  block_t req_data;
  block_t req_key1;
  block_t req_key2;
  logic   req_ready;
  logic   rsp_valid;
  block_t rsp_data;
  logic   rsp_err;
  logic   rsp_ready;

  modport master (
    output req_valid, req_data, req_key1, req_key2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_data, req_key1, req_key2, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/tdes_rr_arb.sv
// Two-way round-robin arbiter, one-hot grant.
// last = index of the requester granted most recently.
module tdes_rr_arb (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (valid)
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/tdes_sched.sv
// Schedules two requesters onto one 3-DES decrypt core,
// with timeout abort and core flush.
module tdes_sched
  import tdes_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int FLUSH_CYCLES   = FLUSH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  tdes_sched_if.slave  ch0,
  tdes_sched_if.slave  ch1,
  output logic         core_ready,
  output logic         core_mode,
  output block_t       core_in_data,
  output block_t       core_key1,
  output block_t       core_key2,
  output logic         core_reset,
  input  block_t       core_out_data,
  input  logic         core_output_ok,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fcnt;
  block_t        op_data, op_k1, op_k2, res_data;
  logic          res_err, owner, last;
  logic [1:0]    gnt;
  logic          accept, done, timeout, flush_done, rsp_hs;

  tdes_rr_arb u_arb (
    .valid ({ch1.req_valid, ch0.req_valid}),
    .last  (last),
    .gnt   (gnt)
  );

  assign ch0.req_ready = (state == S_IDLE) && gnt[0];
  assign ch1.req_ready = (state == S_IDLE) && gnt[1];
  assign accept = ch0.req_ready || ch1.req_ready;

  assign done    = (state == S_WAIT) && core_output_ok;
  assign timeout = (state == S_WAIT) && !core_output_ok &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign flush_done = (state == S_FLUSH) &&
                      (fcnt == FW'(FLUSH_CYCLES - 1));
  assign rsp_hs = (state == S_RESP) &&
                  (owner ? ch1.rsp_ready : ch0.rsp_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (accept) nxt = S_START;
      S_START: nxt = S_WAIT;
      S_WAIT: begin
        if (done)         nxt = S_RESP;
        else if (timeout) nxt = S_FLUSH;
      end
      S_FLUSH: if (flush_done) nxt = S_RESP;
      S_RESP:  if (rsp_hs) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Operands change only on acceptance, so they hold through WAIT/FLUSH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_data  <= '0;
      op_k1    <= '0;
      op_k2    <= '0;
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= '0;
      fcnt     <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      if (accept) begin
        op_data <= gnt[1] ? ch1.req_data : ch0.req_data;
        op_k1   <= gnt[1] ? ch1.req_key1 : ch0.req_key1;
        op_k2   <= gnt[1] ? ch1.req_key2 : ch0.req_key2;
        owner   <= gnt[1];
        last    <= gnt[1];
      end
      if (state == S_START)
        cnt <= '0;
      else if (state == S_WAIT && cnt != CW'(TIMEOUT_CYCLES))
        cnt <= cnt + 1'b1;
      if (state == S_WAIT)
        fcnt <= '0;
      else if (state == S_FLUSH)
        fcnt <= fcnt + 1'b1;
      if (done) begin
        res_data <= core_out_data;
        res_err  <= 1'b0;
      end else if (timeout) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end
    end
  end

  assign core_ready   = (state == S_START);
  assign core_mode    = 1'b1;
  assign core_in_data = op_data;
  assign core_key1    = op_k1;
  assign core_key2    = op_k2;
  assign core_reset   = !reset || (state == S_FLUSH);
  assign busy         = (state != S_IDLE);

  assign ch0.rsp_valid = (state == S_RESP) && !owner;
  assign ch1.rsp_valid = (state == S_RESP) && owner;
  assign ch0.rsp_data  = ch0.rsp_valid ? res_data : '0;
  assign ch1.rsp_data  = ch1.rsp_valid ? res_data : '0;
  assign ch0.rsp_err   = ch0.rsp_valid && res_err;
  assign ch1.rsp_err   = ch1.rsp_valid && res_err;

endmodule

// File: tb/tb_tdes_sched.sv
// Directed bench for tdes_sched with a small behavioural core.
// Table rows cover arbitration and routing; tail covers corners.
module tb_tdes_sched;
  import tdes_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tdes_sched_if i0 ();
  tdes_sched_if i1 ();

  logic   core_ready, core_mode, core_reset, core_output_ok, busy;
  block_t core_in_data, core_key1, core_key2, core_out_data;

  tdes_sched #(.TIMEOUT_CYCLES(16), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .ch0            (i0),
    .ch1            (i1),
    .core_ready     (core_ready),
    .core_mode      (core_mode),
    .core_in_data   (core_in_data),
    .core_key1      (core_key1),
    .core_key2      (core_key2),
    .core_reset     (core_reset),
    .core_out_data  (core_out_data),
    .core_output_ok (core_output_ok),
    .busy           (busy)
  );

  localparam block_t KAT_C = 64'h85E813540F0AB405;
  localparam block_t KAT_K = 64'h133457799BBCDFF1;
  localparam block_t KAT_P = 64'h0123456789ABCDEF;
  localparam block_t K1 = 64'hFFFF0000FFFF0000;
  localparam block_t K2 = 64'h0F0F0F0F0F0F0F0F;

  // Stand-in core: known-answer vector, otherwise data^key1^key2.
  function automatic block_t core_fn(block_t d, block_t a, block_t b);
    if (d == KAT_C && a == KAT_K && b == KAT_K) return KAT_P;
    return d ^ a ^ b;
  endfunction

  logic       core_en = 1'b1;
  logic       spur = 1'b0;
  logic       ok_q = 1'b0;
  logic       pend = 1'b0;
  logic [3:0] lat = 4'd0;
  block_t     out_q = '0;

  always @(posedge clk) begin
    ok_q <= 1'b0;
    if (core_reset) pend <= 1'b0;
    else if (core_ready) begin
      pend <= 1'b1;
      lat  <= 4'd2;
    end else if (pend) begin
      if (lat == 4'd0) begin
        pend  <= 1'b0;
        ok_q  <= core_en;
        out_q <= core_fn(core_in_data, core_key1, core_key2);
      end else lat <= lat - 4'd1;
    end
  end

  assign core_output_ok = ok_q | spur;
  assign core_out_data  = out_q;

  int cyc = 0;
  int pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (core_ready) pulses <= pulses + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic   v0, v1;
    block_t d0, d1, k1, k2;
    logic   gnt;
    block_t exp;
  } vec_t;

  vec_t tv [8];

  task automatic send(input logic v0, input logic v1,
                      input block_t d0, input block_t d1,
                      input block_t k1, input block_t k2,
                      output logic g, output logic ok);
    i0.req_valid = v0; i0.req_data = d0;
    i0.req_key1 = k1;  i0.req_key2 = k2;
    i1.req_valid = v1; i1.req_data = d1;
    i1.req_key1 = k1;  i1.req_key2 = k2;
    g = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (i0.req_ready || i1.req_ready) begin
        g = i1.req_ready;
        ok = 1'b1;
      end
      @(negedge clk);
      if (ok) break;
    end
    i0.req_valid = 1'b0;
    i1.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (i0.rsp_valid || i1.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack(input logic who);
    if (who) i1.rsp_ready = 1'b1;
    else     i0.rsp_ready = 1'b1;
    @(negedge clk);
    i0.rsp_ready = 1'b0;
    i1.rsp_ready = 1'b0;
    #1;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    logic g, ok;
    int   p;
    p = pulses;
    send(v.v0, v.v1, v.d0, v.d1, v.k1, v.k2, g, ok);
    chk($sformatf("r%0d_accept", idx), 64'(ok), 64'd1);
    chk($sformatf("r%0d_grant", idx), 64'(g), 64'(v.gnt));
    wait_rsp(ok);
    chk($sformatf("r%0d_rsp_seen", idx), 64'(ok), 64'd1);
    chk($sformatf("r%0d_own_valid", idx),
        64'(v.gnt ? i1.rsp_valid : i0.rsp_valid), 64'd1);
    chk($sformatf("r%0d_other_valid", idx),
        64'(v.gnt ? i0.rsp_valid : i1.rsp_valid), 64'd0);
    chk($sformatf("r%0d_data", idx),
        v.gnt ? i1.rsp_data : i0.rsp_data, v.exp);
    chk($sformatf("r%0d_err", idx),
        64'(v.gnt ? i1.rsp_err : i0.rsp_err), 64'd0);
    chk($sformatf("r%0d_start_pulses", idx), 64'(pulses - p), 64'd1);
    ack(v.gnt);
    chk($sformatf("r%0d_idle_after_ack", idx), 64'(busy), 64'd0);
  endtask

  initial begin
    logic g, ok, stable;
    int   cs, cf, n, p;
    block_t hold;

    tv[0] = '{1'b1, 1'b1, 64'h1111111111111111, 64'h2222222222222222,
              K1, K2, 1'b0, 64'hE1E11E1EE1E11E1E};
    tv[1] = '{1'b1, 1'b1, 64'h1111111111111111, 64'h2222222222222222,
              K1, K2, 1'b1, 64'hD2D22D2DD2D22D2D};
    tv[2] = '{1'b1, 1'b1, 64'h0000000000000000, 64'h2222222222222222,
              K1, K2, 1'b0, 64'hF0F00F0FF0F00F0F};
    tv[3] = '{1'b1, 1'b1, 64'h1111111111111111, 64'hFFFFFFFFFFFFFFFF,
              K1, K2, 1'b1, 64'h0F0FF0F00F0FF0F0};
    tv[4] = '{1'b1, 1'b0, KAT_C, 64'h0,
              KAT_K, KAT_K, 1'b0, KAT_P};
    tv[5] = '{1'b0, 1'b1, 64'h0, KAT_C,
              KAT_K, KAT_K, 1'b1, KAT_P};
    tv[6] = '{1'b0, 1'b1, 64'h0, 64'h0,
              K1, K2, 1'b1, 64'hF0F00F0FF0F00F0F};
    tv[7] = '{1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0,
              K1, K2, 1'b0, 64'h0F0FF0F00F0FF0F0};

    i0.req_valid = 1'b0; i0.req_data = '0; i0.req_key1 = '0;
    i0.req_key2 = '0;    i0.rsp_ready = 1'b0;
    i1.req_valid = 1'b0; i1.req_data = '0; i1.req_key1 = '0;
    i1.req_key2 = '0;    i1.rsp_ready = 1'b0;

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_core_mode", 64'(core_mode), 64'd1);
    chk("rst_core_ready", 64'(core_ready), 64'd0);
    chk("rst_core_data", core_in_data, 64'd0);
    chk("rst_rsp_valid", 64'(i0.rsp_valid | i1.rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_core_reset", 64'(core_reset), 64'd0);

    foreach (tv[i]) run_row(tv[i], i);

    // Spurious core strobes while idle must be ignored.
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_rsp", 64'(i0.rsp_valid | i1.rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("spur_rsp_later", 64'(i0.rsp_valid | i1.rsp_valid), 64'd0);
    run_row(tv[4], 20);

    // Response back-pressure: held response, no new grant.
    send(1'b1, 1'b0, 64'h0, 64'h0, K1, K2, g, ok);
    wait_rsp(ok);
    chk("stall_rsp_seen", 64'(ok), 64'd1);
    hold = i0.rsp_data;
    chk("stall_data", hold, 64'hF0F00F0FF0F00F0F);
    p = pulses;
    i1.req_valid = 1'b1;
    i1.req_data = KAT_C;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (!i0.rsp_valid || i0.rsp_data !== hold || !busy ||
          i1.req_ready || i1.rsp_valid)
        stable = 1'b0;
    end
    chk("stall_stable", 64'(stable), 64'd1);
    chk("stall_no_start", 64'(pulses - p), 64'd0);
    i1.req_valid = 1'b0;
    ack(1'b0);
    chk("stall_idle", 64'(busy), 64'd0);

    // Core never answers: 16 WAIT cycles, then 2 flush cycles.
    core_en = 1'b0;
    send(1'b1, 1'b0, 64'h1111111111111111, 64'h0, K1, K2, g, ok);
    #1;
    chk("to_start", 64'(core_ready), 64'd1);
    cs = cyc;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (core_reset) break;
    end
    cf = cyc;
    chk("to_flush_dist", 64'(cf - cs), 64'd17);
    n = 0;
    while (core_reset && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("to_flush_len", 64'(n), 64'd2);
    chk("to_rsp_valid", 64'(i0.rsp_valid), 64'd1);
    chk("to_rsp_err", 64'(i0.rsp_err), 64'd1);
    chk("to_rsp_data", i0.rsp_data, 64'd0);
    ack(1'b0);

    // Asynchronous reset in the middle of WAIT.
    send(1'b0, 1'b1, 64'h0, KAT_C, KAT_K, KAT_K, g, ok);
    repeat (3) @(negedge clk);
    #1;
    chk("mid_busy_before", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_core_reset", 64'(core_reset), 64'd1);
    chk("mid_core_data", core_in_data, 64'd0);
    chk("mid_core_mode", 64'(core_mode), 64'd1);
    chk("mid_rsp", 64'(i0.rsp_valid | i1.rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    core_en = 1'b1;
    run_row(tv[0], 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
